// File: rtl/rtc_bus_cycle_gen_if.sv
// rtc_bus_cycle_gen_if: request/response and RTC pad signals of rtc_bus_cycle_gen
//   req/rw/addr/wdata : one register-access request from upstream control logic
//   ad_in             : AD bus value seen at the pad
//   ad_out/ad_oe      : AD bus drive value and enable
//   cs_n/ad_n/rd_n/wr_n : active-low chip strobes
//   rdata/busy/done   : read result, cycle-in-progress flag, end-of-cycle pulse
interface rtc_bus_cycle_gen_if;
    logic       req;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       ad_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    modport slave (
        input  req, rw, addr, wdata, ad_in,
        output ad_out, ad_oe, cs_n, ad_n, rd_n, wr_n, rdata, busy, done
    );
    modport master (
        output req, rw, addr, wdata, ad_in,
        input  ad_out, ad_oe, cs_n, ad_n, rd_n, wr_n, rdata, busy, done
    );
endinterface

// File: rtl/rtc_bus_cycle_gen.sv
// rtc_bus_cycle_gen: sequences one multiplexed address/data bus cycle to the RTC chip
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request, pad and status signals (see rtc_bus_cycle_gen_if)
//   PHASE_CYC : WR/RD strobe width in cycles (1..255)
//   GAP_CYC   : setup/hold/recovery width in cycles (1..255)
module rtc_bus_cycle_gen #(
    parameter int PHASE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input logic clk,
    input logic rst_n,
    rtc_bus_cycle_gen_if.slave bus
);
    // Encoding is sequential so each phase advances by +1; RECOVER wraps to IDLE.
    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, RECOVER
    } state_t;
    localparam logic [7:0] PH_LD = 8'(PHASE_CYC - 1);
    localparam logic [7:0] GP_LD = 8'(GAP_CYC - 1);
    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] addr_q, wdata_q;
    logic       rw_q;
    logic       last, a_ph, d_ph;
    logic       n_cs_n, n_ad_n, n_rd_n, n_wr_n, n_oe, n_busy, n_done;
    logic [7:0] n_out;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end
    // Outputs are decoded from the next state and registered, so pads see
    // glitch-free strobes aligned with the state they belong to.
    always_comb begin
        last      = cnt == 8'd0;
        state_nxt = state;
        if (state == IDLE)
            state_nxt = bus.req ? A_SETUP : IDLE;
        else if (last)
            state_nxt = state_t'(state + 3'd1);
        cnt_nxt = cnt - 8'd1;
        if (state_nxt != state || state == IDLE)
            cnt_nxt = (state_nxt == A_STROBE || state_nxt == D_STROBE) ? PH_LD :
                      (state_nxt == IDLE) ? 8'd0 : GP_LD;
        a_ph   = state_nxt inside {A_SETUP, A_STROBE, A_HOLD};
        d_ph   = state_nxt inside {D_SETUP, D_STROBE, D_HOLD} && !rw_q;
        n_cs_n = state_nxt == IDLE || state_nxt == RECOVER;
        n_ad_n = !a_ph;
        n_wr_n = !(state_nxt == A_STROBE || (state_nxt == D_STROBE && !rw_q));
        n_rd_n = !(state_nxt == D_STROBE && rw_q);
        n_oe   = a_ph || d_ph;
        // On acceptance the address is not latched yet, so take it from the request.
        n_out  = a_ph ? (state == IDLE ? bus.addr : addr_q) : d_ph ? wdata_q : 8'h00;
        n_busy = state_nxt != IDLE;
        n_done = state == RECOVER && last;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            bus.cs_n   <= 1'b1;
            bus.ad_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            bus.wr_n   <= 1'b1;
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= '0;
            bus.rdata  <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            if (state == IDLE && bus.req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                rw_q    <= bus.rw;
            end
            if (state == D_STROBE && last && rw_q)
                bus.rdata <= bus.ad_in;
            bus.cs_n   <= n_cs_n;
            bus.ad_n   <= n_ad_n;
            bus.rd_n   <= n_rd_n;
            bus.wr_n   <= n_wr_n;
            bus.ad_oe  <= n_oe;
            bus.ad_out <= n_out;
            bus.busy   <= n_busy;
            bus.done   <= n_done;
        end
    end
endmodule

// File: tb/tb_rtc_bus_cycle_gen.sv
// tb_rtc_bus_cycle_gen: self-checking bench for rtc_bus_cycle_gen (default and 1/1 timing)
module tb_rtc_bus_cycle_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rtc_bus_cycle_gen_if bi0 ();
    rtc_bus_cycle_gen_if bi1 ();
    rtc_bus_cycle_gen #(.PHASE_CYC(4), .GAP_CYC(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0.slave));
    rtc_bus_cycle_gen #(.PHASE_CYC(1), .GAP_CYC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bi1.slave));

    typedef struct packed {
        logic       cs_n, ad_n, rd_n, wr_n, ad_oe;
        logic [7:0] ad_out, rdata;
        logic       busy, done;
    } obs_t;

    typedef struct {
        bit         rw;
        logic [7:0] addr, wdata, ad_in;
        int         cs_first, cs_last, wr_cnt, rd_first, rd_last, done0, done1, addr_cyc, data_cyc;
        logic [7:0] rdata;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int n = 0;

    // Reference model: elapsed cycle count since acceptance, phase boundaries by arithmetic.
    int         G [2] = '{2, 1};
    int         P [2] = '{4, 1};
    bit         act [2];
    int         t [2];
    logic [7:0] la [2], ld [2], rd_e [2];
    bit         lr [2], dn_e [2];

    function automatic void reset_model();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; t[i] = 0; la[i] = 0; ld[i] = 0; lr[i] = 0; rd_e[i] = 0; dn_e[i] = 0;
        end
    endfunction

    function automatic obs_t expect_o(int i);
        obs_t o;
        int e1, e2, e3, e4, e5, e6;
        bit ap, dp;
        o = {4'hF, 1'b0, 8'h00, rd_e[i], 1'b0, dn_e[i]};
        if (act[i]) begin
            e1 = G[i]; e2 = e1 + P[i]; e3 = e2 + G[i]; e4 = e3 + G[i]; e5 = e4 + P[i]; e6 = e5 + G[i];
            ap = t[i] <= e3;
            dp = t[i] > e3 && t[i] <= e6;
            o.cs_n   = t[i] > e6;
            o.ad_n   = !ap;
            o.wr_n   = !((t[i] > e1 && t[i] <= e2) || (!lr[i] && t[i] > e4 && t[i] <= e5));
            o.rd_n   = !(lr[i] && t[i] > e4 && t[i] <= e5);
            o.ad_oe  = ap || (dp && !lr[i]);
            o.ad_out = ap ? la[i] : (dp && !lr[i]) ? ld[i] : 8'h00;
            o.busy   = 1'b1;
        end
        return o;
    endfunction

    function automatic void model_edge(bit rq, bit rw_i, logic [7:0] a, logic [7:0] d, logic [7:0] ai);
        for (int i = 0; i < 2; i++) begin
            if (!act[i]) begin
                dn_e[i] = 0;
                if (rq) begin
                    act[i] = 1; t[i] = 1; la[i] = a; ld[i] = d; lr[i] = rw_i;
                end
            end else begin
                if (lr[i] && t[i] == 3 * G[i] + 2 * P[i]) rd_e[i] = ai;
                if (t[i] == 5 * G[i] + 2 * P[i]) begin
                    act[i] = 0; dn_e[i] = 1;
                end else t[i]++;
            end
        end
    endfunction

    function automatic obs_t sample(int i);
        return (i == 0) ?
            {bi0.cs_n, bi0.ad_n, bi0.rd_n, bi0.wr_n, bi0.ad_oe, bi0.ad_out, bi0.rdata, bi0.busy, bi0.done} :
            {bi1.cs_n, bi1.ad_n, bi1.rd_n, bi1.wr_n, bi1.ad_oe, bi1.ad_out, bi1.rdata, bi1.busy, bi1.done};
    endfunction

    task automatic check_model();
        obs_t e, g;
        for (int i = 0; i < 2; i++) begin
            e = expect_o(i);
            g = sample(i);
            // ad_out is don't-care while the bus is released inside a read's data phase
            if (!e.ad_oe && e.busy && !e.cs_n) g.ad_out = e.ad_out;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL model cyc%0d dut%0d: got %h expected %h", n, i, g, e);
            end
        end
    endtask

    task automatic chk(string nm, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic cyc(bit rq, bit rw_i, logic [7:0] a, logic [7:0] d, logic [7:0] ai);
        bi0.req = rq; bi0.rw = rw_i; bi0.addr = a; bi0.wdata = d; bi0.ad_in = ai;
        bi1.req = rq; bi1.rw = rw_i; bi1.addr = a; bi1.wdata = d; bi1.ad_in = ai;
        @(posedge clk);
        model_edge(rq, rw_i, a, d, ai);
        @(negedge clk);
        n++;
        check_model();
    endtask

    // One request, then inverted inputs so that latching of the request is exercised.
    task automatic run_vec(input vec_t v, input int k);
        int csf = 0, csl = 0, wrc = 0, rdf = 0, rdl = 0, d0 = 0, d1 = 0, ac = 0, dc = 0;
        for (int j = 0; j < 24; j++) begin
            if (j == 0) cyc(1, v.rw, v.addr, v.wdata, v.ad_in);
            else cyc(0, !v.rw, ~v.addr, ~v.wdata, v.ad_in);
            if (!bi0.cs_n) begin if (csf == 0) csf = j + 1; csl = j + 1; end
            if (!bi0.wr_n) wrc++;
            if (!bi0.rd_n) begin if (rdf == 0) rdf = j + 1; rdl = j + 1; end
            if (bi0.done && d0 == 0) d0 = j + 1;
            if (bi1.done && d1 == 0) d1 = j + 1;
            if (bi0.ad_oe && bi0.ad_out == v.addr) ac++;
            if (bi0.ad_oe && bi0.ad_out == v.wdata) dc++;
        end
        chk($sformatf("v%0d cs_first", k), csf, v.cs_first);
        chk($sformatf("v%0d cs_last", k), csl, v.cs_last);
        chk($sformatf("v%0d wr_cnt", k), wrc, v.wr_cnt);
        chk($sformatf("v%0d rd_first", k), rdf, v.rd_first);
        chk($sformatf("v%0d rd_last", k), rdl, v.rd_last);
        chk($sformatf("v%0d done0", k), d0, v.done0);
        chk($sformatf("v%0d done1", k), d1, v.done1);
        chk($sformatf("v%0d addr_cyc", k), ac, v.addr_cyc);
        chk($sformatf("v%0d data_cyc", k), dc, v.data_cyc);
        chk($sformatf("v%0d rdata", k), bi0.rdata, v.rdata);
    endtask

    vec_t vecs [4];

    initial begin
        int dones, seen, d0;
        vecs[0] = '{0, 8'h21, 8'h45, 8'h00, 1, 16, 8, 0, 0, 19, 8, 8, 8, 8'h00};
        vecs[1] = '{1, 8'h22, 8'h66, 8'h13, 1, 16, 4, 11, 14, 19, 8, 8, 0, 8'h13};
        vecs[2] = '{0, 8'h5A, 8'h77, 8'hEE, 1, 16, 8, 0, 0, 19, 8, 8, 8, 8'h13};
        vecs[3] = '{1, 8'h81, 8'h3C, 8'hC4, 1, 16, 4, 11, 14, 19, 8, 8, 0, 8'hC4};
        reset_model();
        bi0.req = 0; bi0.rw = 0; bi0.addr = 0; bi0.wdata = 0; bi0.ad_in = 0;
        bi1.req = 0; bi1.rw = 0; bi1.addr = 0; bi1.wdata = 0; bi1.ad_in = 0;
        repeat (2) @(negedge clk);
        check_model();
        rst_n = 1'b1;
        cyc(0, 0, 8'h00, 8'h00, 8'h00);

        for (int k = 0; k < 4; k++) run_vec(vecs[k], k);

        // Request pulsed while busy must be ignored.
        dones = 0; seen = 0;
        for (int j = 0; j < 30; j++) begin
            if (j == 0) cyc(1, 0, 8'h30, 8'h31, 8'h00);
            else cyc(j == 5, 0, 8'h0F, 8'h0F, 8'h00);
            if (bi0.done) dones++;
            if (bi0.ad_oe && bi0.ad_out == 8'h0F) seen++;
        end
        chk("busy_req done_pulses", dones, 1);
        chk("busy_req addr_0F_seen", seen, 0);

        // Asynchronous reset in the middle of a read.
        cyc(1, 1, 8'h22, 8'h00, 8'h99);
        for (int j = 1; j < 10; j++) cyc(0, 1, 8'h22, 8'h00, 8'h99);
        #1 rst_n = 1'b0;
        #1;
        reset_model();
        check_model();
        chk("reset rdata", bi0.rdata, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = 0;
        for (int j = 0; j < 22; j++) begin
            if (j == 0) cyc(1, 0, 8'h44, 8'h55, 8'h00);
            else cyc(0, 0, 8'h00, 8'h00, 8'h00);
            if (bi0.done && d0 == 0) d0 = j + 1;
        end
        chk("after_reset done_at", d0, 19);

        // req held high across two back-to-back writes.
        cyc(1, 0, 8'h01, 8'hAA, 8'h00);
        for (int j = 1; j < 23; j++) begin
            cyc(1, 0, 8'h02, 8'hBB, 8'h00);
            if (j >= 16 && j <= 18) chk($sformatf("b2b cs_n_high c%0d", j + 1), bi0.cs_n, 1);
            if (j == 19) begin
                chk("b2b cs_n_low c20", bi0.cs_n, 0);
                chk("b2b ad_out c20", bi0.ad_out, 8'h02);
            end
        end
        for (int j = 0; j < 25; j++) cyc(0, 0, 8'h00, 8'h00, 8'h00);

        // Random traffic against the model.
        for (int j = 0; j < 400; j++)
            cyc($urandom_range(0, 3) == 0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        for (int j = 0; j < 25; j++) cyc(0, 0, 8'h00, 8'h00, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
